// File: rtl/clock_timer_unit.sv
// Free-running cycle counter, prescaled tick counter and per-channel tick
// compare interrupts behind a 32-bit word-addressed register port.
// Optional feature: define CLOCK_TIMER_SNAPSHOT_EN so that a lo read latches the
// counter's upper word, and the next hi read returns that latched word (atomic
// 64-bit read).
module clock_timer_unit #(
  parameter int unsigned COUNTER_WIDTH = 64,
  parameter int unsigned TICK_DIVISOR  = 50000,
  parameter int unsigned NUM_CHANNELS  = 2
) (
  input  logic                     core_clock,
  input  logic                     reset,
  input  logic                     count_en,
  input  logic                     rd_en,
  input  logic                     wr_en,
  input  logic [3:0]               addr,
  input  logic [31:0]              wr_data,
  output logic [31:0]              rd_data,
  output logic                     rd_valid,
  output logic [COUNTER_WIDTH-1:0] cycle_count,
  output logic [COUNTER_WIDTH-1:0] tick_count,
  output logic [NUM_CHANNELS-1:0]  irq
);

  localparam int unsigned W  = COUNTER_WIDTH;
  localparam int unsigned HW = COUNTER_WIDTH - 32;
  localparam int unsigned PW = $clog2(TICK_DIVISOR);
  localparam logic [PW-1:0] PresMax = PW'(TICK_DIVISOR - 1);

  logic [W-1:0]  cycle_q, cycle_d;
  logic [W-1:0]  tick_q, tick_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0]  cmp_q [NUM_CHANNELS];
  logic [W-1:0]  cmp_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] irq_q, irq_d;
  logic [31:0]   rd_data_q, rd_word;
  logic          rd_valid_q;

  logic [63:0]   c64, t64;
  logic [2:0]    ch_idx;
  logic          ch_hit, cyc_wr, tick_wr;

  // Channel k lives at word pair 4+2k/5+2k.
  assign ch_idx  = addr[3:1] - 3'd2;
  assign ch_hit  = (addr[3:2] != 2'b00) && (32'(ch_idx) < NUM_CHANNELS);
  assign cyc_wr  = wr_en && (addr[3:1] == 3'd0);
  assign tick_wr = wr_en && (addr[3:1] == 3'd1);
  assign c64     = 64'(cycle_q);
  assign t64     = 64'(tick_q);

`ifdef CLOCK_TIMER_SNAPSHOT_EN
  logic [31:0] cyc_snap_q, tick_snap_q;

  // Capture upper words on lo reads so a following hi read is coherent.
  always_ff @(posedge core_clock or posedge reset) begin
    if (reset) begin
      cyc_snap_q  <= '0;
      tick_snap_q <= '0;
    end else if (rd_en) begin
      if (addr == 4'd0) cyc_snap_q  <= c64[63:32];
      if (addr == 4'd2) tick_snap_q <= t64[63:32];
    end
  end
`endif

  // Counter, prescaler and compare next-state; writes override increments.
  always_comb begin
    cycle_d = cycle_q;
    tick_d  = tick_q;
    presc_d = presc_q;
    for (int k = 0; k < NUM_CHANNELS; k++) cmp_d[k] = cmp_q[k];

    if (count_en) begin
      cycle_d = cycle_q + W'(1);
      if (presc_q == PresMax) begin
        presc_d = '0;
        tick_d  = tick_q + W'(1);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    if (cyc_wr) begin
      cycle_d = cycle_q;
      if (addr[0]) cycle_d[W-1:32] = wr_data[HW-1:0];
      else         cycle_d[31:0]   = wr_data;
    end

    if (tick_wr) begin
      tick_d  = tick_q;
      presc_d = '0;
      if (addr[0]) tick_d[W-1:32] = wr_data[HW-1:0];
      else         tick_d[31:0]   = wr_data;
    end

    if (wr_en && ch_hit) begin
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        if (3'(k) == ch_idx) begin
          if (addr[0]) cmp_d[k][W-1:32] = wr_data[HW-1:0];
          else         cmp_d[k][31:0]   = wr_data;
        end
      end
    end
  end

  // Interrupt levels compare the current registers, so they lag by one cycle.
  always_comb begin
    irq_d = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) irq_d[k] = (tick_q >= cmp_q[k]);
  end

  // Read mux over pre-write register values; unmapped words read as zero.
  always_comb begin
    rd_word = '0;
    case (addr[3:1])
      3'd0: begin
`ifdef CLOCK_TIMER_SNAPSHOT_EN
        rd_word = addr[0] ? cyc_snap_q : c64[31:0];
`else
        rd_word = addr[0] ? c64[63:32] : c64[31:0];
`endif
      end
      3'd1: begin
`ifdef CLOCK_TIMER_SNAPSHOT_EN
        rd_word = addr[0] ? tick_snap_q : t64[31:0];
`else
        rd_word = addr[0] ? t64[63:32] : t64[31:0];
`endif
      end
      default: begin
        if (ch_hit) begin
          for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (3'(k) == ch_idx) begin
              rd_word = addr[0] ? 32'(cmp_q[k] >> 32) : cmp_q[k][31:0];
            end
          end
        end
      end
    endcase
  end

  // Counter and prescaler state.
  always_ff @(posedge core_clock or posedge reset) begin
    if (reset) begin
      cycle_q <= '0;
      tick_q  <= '0;
      presc_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      tick_q  <= tick_d;
      presc_q <= presc_d;
    end
  end

  // Compare registers reset to all ones so no channel fires out of reset.
  always_ff @(posedge core_clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_CHANNELS; k++) cmp_q[k] <= '1;
    end else begin
      for (int k = 0; k < NUM_CHANNELS; k++) cmp_q[k] <= cmp_d[k];
    end
  end

  // Registered interrupt outputs.
  always_ff @(posedge core_clock or posedge reset) begin
    if (reset) irq_q <= '0;
    else       irq_q <= irq_d;
  end

  // Read response: data updates only on a read, so it holds between pulses.
  always_ff @(posedge core_clock or posedge reset) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= rd_word;
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign cycle_count = cycle_q;
  assign tick_count  = tick_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_clock_timer_unit.sv
// Directed bench for clock_timer_unit (TICK_DIVISOR=4, two channels, 64-bit).
// Read responses are checked against a queue of expected words.
module tb_clock_timer_unit;

  logic        core_clock;
  logic        reset;
  logic        count_en;
  logic        rd_en;
  logic        wr_en;
  logic [3:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [63:0] cycle_count;
  logic [63:0] tick_count;
  logic [1:0]  irq;

  int unsigned n_cmp;
  int unsigned n_err;
  logic [31:0] sb [$];
  logic [31:0] hold;

  clock_timer_unit #(
    .COUNTER_WIDTH(64),
    .TICK_DIVISOR (4),
    .NUM_CHANNELS (2)
  ) dut (
    .core_clock (core_clock),
    .reset      (reset),
    .count_en   (count_en),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .addr       (addr),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .cycle_count(cycle_count),
    .tick_count (tick_count),
    .irq        (irq)
  );

  initial core_clock = 1'b0;
  always #5 core_clock = ~core_clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and check the read port against the scoreboard.
  task automatic cycle();
    logic exp_v;
    @(posedge core_clock);
    #1;
    if (!reset) begin
      exp_v = (sb.size() != 0);
      check("rd_valid", {63'b0, rd_valid}, {63'b0, exp_v});
      if (exp_v) begin
        hold = sb.pop_front();
        check("rd_data", {32'b0, rd_data}, {32'b0, hold});
      end else begin
        check("rd_hold", {32'b0, rd_data}, {32'b0, hold});
      end
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wr_data = d;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp);
    rd_en = 1'b1; addr = a;
    sb.push_back(exp);
    cycle();
    rd_en = 1'b0;
  endtask

  initial begin
    logic [63:0] exp_tick, prev_tick;
    logic [1:0]  exp_presc;
    n_cmp = 0; n_err = 0; hold = '0;
    reset = 1'b1; count_en = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    addr = '0; wr_data = '0;
    repeat (2) @(posedge core_clock);
    #1;
    check("rst_cycle", cycle_count, 64'd0);
    check("rst_tick", tick_count, 64'd0);
    check("rst_irq", {62'b0, irq}, 64'd0);
    check("rst_rd_valid", {63'b0, rd_valid}, 64'd0);
    check("rst_rd_data", {32'b0, rd_data}, 64'd0);
    reset = 1'b0;

    // 12 counting cycles: three full ticks.
    count_en = 1'b1;
    repeat (12) cycle();
    count_en = 1'b0;
    check("cnt12_cycle", cycle_count, 64'd12);
    check("cnt12_tick", tick_count, 64'd3);
    check("cnt12_irq", {62'b0, irq}, 64'd0);

    // Writes beat a same-cycle increment; then wrap to zero.
    count_en = 1'b1;
    wr(4'd0, 32'hFFFF_FFFF);
    check("wr_lo_wins", cycle_count, 64'h0000_0000_FFFF_FFFF);
    wr(4'd1, 32'hFFFF_FFFF);
    check("wr_hi_wins", cycle_count, 64'hFFFF_FFFF_FFFF_FFFF);
    cycle();
    check("cycle_wrap", cycle_count, 64'd0);
    count_en = 1'b0;
    cycle();
    check("cycle_hold", cycle_count, 64'd0);

    // Clear tick (and prescaler), set compare0 = 5.
    wr(4'd2, 32'd0);
    check("tick_cleared", tick_count, 64'd0);
    wr(4'd4, 32'd5);
    wr(4'd5, 32'd0);
    check("irq_pre", {62'b0, irq}, 64'd0);

    // irq[0] follows tick>=5 one cycle late; irq[1] never fires.
    exp_tick = 64'd0; exp_presc = 2'd0;
    count_en = 1'b1;
    for (int i = 0; i < 22; i++) begin
      prev_tick = exp_tick;
      if (exp_presc == 2'd3) begin
        exp_presc = 2'd0;
        exp_tick  = exp_tick + 64'd1;
      end else begin
        exp_presc = exp_presc + 2'd1;
      end
      cycle();
      check("tick_run", tick_count, exp_tick);
      check("irq_run", {62'b0, irq}, {63'b0, (prev_tick >= 64'd5)});
    end
    count_en = 1'b0;

    // Raising compare0 above tick drops irq[0] one edge after the write edge.
    wr(4'd4, 32'd100);
    check("irq_after_wr", {62'b0, irq}, 64'd1);
    cycle();
    check("irq_cleared", {62'b0, irq}, 64'd0);

    // Register reads, including unmapped channel 2.
    wr(4'd9, 32'd7);
    rd(4'd2, 32'd5);
    rd(4'd9, 32'd0);
    rd(4'd4, 32'd100);
    rd(4'd5, 32'd0);
    rd(4'd0, 32'd22);
    rd(4'd1, 32'd0);
    rd(4'd7, 32'hFFFF_FFFF);
    rd(4'd15, 32'd0);
    cycle();

    // Simultaneous read and write to one address returns the old value.
    wr_en = 1'b1; wr_data = 32'h0000_1234;
    rd(4'd6, 32'hFFFF_FFFF);
    wr_en = 1'b0;
    rd(4'd6, 32'h0000_1234);

    // Carry across the 32-bit boundary between lo and hi reads.
    wr(4'd2, 32'hFFFF_FFFF);
    wr(4'd3, 32'd0);
    rd(4'd2, 32'hFFFF_FFFF);
    count_en = 1'b1;
    repeat (4) cycle();
    count_en = 1'b0;
    check("tick_carry", tick_count, 64'h0000_0001_0000_0000);
`ifdef CLOCK_TIMER_SNAPSHOT_EN
    rd(4'd3, 32'd0);
`else
    rd(4'd3, 32'd1);
`endif
    cycle();

    // Reset lands while a read is pending: no response, outputs cleared.
    count_en = 1'b1;
    rd_en = 1'b1; addr = 4'd2;
    #3;
    reset = 1'b1;
    hold = '0;
    #1;
    check("rst_mid_valid", {63'b0, rd_valid}, 64'd0);
    check("rst_mid_data", {32'b0, rd_data}, 64'd0);
    check("rst_mid_cycle", cycle_count, 64'd0);
    check("rst_mid_tick", tick_count, 64'd0);
    check("rst_mid_irq", {62'b0, irq}, 64'd0);
    @(posedge core_clock);
    #1;
    check("rst_edge_valid", {63'b0, rd_valid}, 64'd0);
    rd_en = 1'b0; count_en = 1'b0;
    reset = 1'b0;
    repeat (2) cycle();
    check("post_rst_irq", {62'b0, irq}, 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
